cond_unit: RTL and testbench

Conditional-execution stage placed directly downstream of the instruction decoder in the single-cycle ARM datapath. It holds the architectural NZCV status flags and evaluates the instruction's 4-bit condition field against them. It gates the decoder's raw write and branch enables (PCS, RegW, MemW) into the committed PCSrc, RegWrite and MemWrite signals. It also updates the flag register from the ALU under control of the decoder's FlagW.

---
 rtl/arm_pkg.sv | 28 ++
 rtl/cond_unit_if.sv | 27 ++
 rtl/cond_check.sv | 40 ++++
 rtl/cond_unit.sv | 44 ++++
 tb/tb_cond_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: condition-field encodings and NZCV bit positions.
package arm_pkg;

  typedef enum logic [3:0] {
    CondEq = 4'h0,
    CondNe = 4'h1,
    CondCs = 4'h2,
    CondCc = 4'h3,
    CondMi = 4'h4,
    CondPl = 4'h5,
    CondVs = 4'h6,
    CondVc = 4'h7,
    CondHi = 4'h8,
    CondLs = 4'h9,
    CondGe = 4'hA,
    CondLt = 4'hB,
    CondGt = 4'hC,
    CondLe = 4'hD,
    CondAl = 4'hE,
    CondNv = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Decoder/ALU-facing signals of the conditional-execution stage.
interface cond_unit_if;

  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

endinterface

// File: rtl/cond_check.sv
// Combinational evaluation of the 4-bit condition field against the NZCV flags.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_e'(cond_i))
      CondEq:  cond_ex_o = z;
      CondNe:  cond_ex_o = ~z;
      CondCs:  cond_ex_o = c;
      CondCc:  cond_ex_o = ~c;
      CondMi:  cond_ex_o = n;
      CondPl:  cond_ex_o = ~n;
      CondVs:  cond_ex_o = v;
      CondVc:  cond_ex_o = ~v;
      CondHi:  cond_ex_o = c & ~z;
      CondLs:  cond_ex_o = ~c | z;
      CondGe:  cond_ex_o = (n == v);
      CondLt:  cond_ex_o = (n != v);
      CondGt:  cond_ex_o = ~z & (n == v);
      CondLe:  cond_ex_o = z | (n != v);
      CondAl:  cond_ex_o = 1'b1;
      CondNv:  cond_ex_o = 1'b0;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV, gates decoder write enables by the condition result.
module cond_unit
  import arm_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  cond_unit_if.slave bus
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       cond_ex;

  // Condition is evaluated on the registered flags only; no bypass from ALUFlags.
  cond_check u_cond_check (
    .cond_i    (bus.Cond),
    .flags_i   ({nz_q, cv_q}),
    .cond_ex_o (cond_ex)
  );

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (bus.FlagW[1] && cond_ex) nz_d = bus.ALUFlags[FLAG_N:FLAG_Z];
    if (bus.FlagW[0] && cond_ex) cv_d = bus.ALUFlags[FLAG_C:FLAG_V];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS & cond_ex;
  assign bus.RegWrite = bus.RegW & cond_ex & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & cond_ex;
  assign bus.Flags    = {nz_q, cv_q};

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus pushes model expectations, a negedge monitor checks them.
module tb_cond_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cond_unit_if bus_if ();

  cond_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    string      tag;
    logic [3:0] flags;
    logic       ce;
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: architectural flags plus the instruction currently presented.
  logic [3:0] m_flags  = 4'h0;
  logic [3:0] last_alu = 4'h0;
  logic [1:0] last_fw  = 2'b00;
  logic       last_ce  = 1'b0;

  // ARM conditions come in pairs; the odd encoding is the negation of the even one.
  function automatic logic model_cond(logic [3:0] cond, logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  function automatic void chk(string tag, string name, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s/%s: got %h, expected %h at %0t", tag, name, act, req, $time);
    end
  endfunction

  task automatic issue(string tag, logic rst_val, logic [3:0] cond, logic [1:0] fw,
                       logic [3:0] alu, logic pcs, logic regw, logic memw, logic nowr);
    exp_t e;
    @(posedge clk);
    #1;
    // Commit the previous instruction's flag write if the edge saw reset released.
    if (rst_n && last_ce) begin
      if (last_fw[1]) m_flags[3:2] = last_alu[3:2];
      if (last_fw[0]) m_flags[1:0] = last_alu[1:0];
    end
    rst_n = rst_val;
    if (!rst_val) m_flags = 4'h0;
    bus_if.Cond     = cond;
    bus_if.FlagW    = fw;
    bus_if.ALUFlags = alu;
    bus_if.PCS      = pcs;
    bus_if.RegW     = regw;
    bus_if.MemW     = memw;
    bus_if.NoWrite  = nowr;
    e.tag      = tag;
    e.flags    = m_flags;
    e.ce       = model_cond(cond, m_flags);
    e.pcsrc    = pcs && e.ce;
    e.regwrite = regw && e.ce && !nowr;
    e.memwrite = memw && e.ce;
    exp_q.push_back(e);
    last_alu = alu;
    last_fw  = fw;
    last_ce  = e.ce;
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "Flags", bus_if.Flags, e.flags);
        chk(e.tag, "CondEx", {3'b000, bus_if.CondEx}, {3'b000, e.ce});
        chk(e.tag, "PCSrc", {3'b000, bus_if.PCSrc}, {3'b000, e.pcsrc});
        chk(e.tag, "RegWrite", {3'b000, bus_if.RegWrite}, {3'b000, e.regwrite});
        chk(e.tag, "MemWrite", {3'b000, bus_if.MemWrite}, {3'b000, e.memwrite});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.Cond     = 4'hE;
    bus_if.FlagW    = 2'b11;
    bus_if.ALUFlags = 4'hF;
    bus_if.PCS      = 1'b0;
    bus_if.RegW     = 1'b0;
    bus_if.MemW     = 1'b0;
    bus_if.NoWrite  = 1'b0;

    // Reset held across three edges with a flag write requested.
    repeat (3) issue("reset", 1'b0, 4'hE, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);

    // Independent halves.
    issue("split_nz", 1'b1, 4'hE, 2'b10, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("split_cv0", 1'b1, 4'hE, 2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("split_cv1", 1'b1, 4'hE, 2'b01, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("split_obs", 1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Failed condition gates enables and flag writes.
    issue("gate_ld", 1'b1, 4'hE, 2'b11, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("gate_ne", 1'b1, 4'h1, 2'b11, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    issue("gate_obs", 1'b1, 4'hE, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Compare-type instruction followed by a dependent conditional write.
    issue("cmp", 1'b1, 4'hE, 2'b11, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1);
    issue("cmp_eq", 1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Every condition against every flag value.
    for (int f = 0; f < 16; f++) begin
      issue("sweep_ld", 1'b1, 4'hE, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) begin
        issue("sweep", 1'b1, 4'(c), 2'b00, 4'($urandom_range(15)), 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
    end

    // Asynchronous reset between edges, with a flag write pending at that moment.
    issue("async_ld", 1'b1, 4'hE, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("async_pre", 1'b1, 4'hE, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("async_rst", 1'b0, 4'hE, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    issue("async_post", 1'b1, 4'h0, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Random instruction stream with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      issue("rand", 1'($urandom_range(39) != 0), 4'($urandom_range(15)),
            2'($urandom_range(3)), 4'($urandom_range(15)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
